// File: rtl/luhn_pkg.sv
// rtl/luhn_pkg.sv - shared FSM states and mode encodings for the Luhn mod-N engine
//
// No ports. Holds the controller state enum and the size_mode encodings.

package luhn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } luhn_state_t;

   localparam logic MODE_VERIFY = 1'b0;
   localparam logic MODE_GEN    = 1'b1;

endpackage

// File: rtl/luhn_mod_n_term.sv
// rtl/luhn_mod_n_term.sv - combinational Luhn term for one digit
//
// Ports:
//   d            in   DIGIT_W  digit value
//   dbl          in   1        digit sits in a doubled position
//   t            out  DIGIT_W  term to accumulate, always < RADIX
//   out_of_range out  1        d >= RADIX; t is forced to 0

module luhn_mod_n_term #(
   parameter int DIGIT_W = 4,
   parameter int RADIX   = 16
) (
   input  logic [DIGIT_W-1:0] d,
   input  logic               dbl,
   output logic [DIGIT_W-1:0] t,
   output logic               out_of_range
);

   // One extra bit so RADIX == 2**DIGIT_W and 2*d are both representable.
   localparam logic [DIGIT_W:0] RAD = (DIGIT_W+1)'(RADIX);

   logic [DIGIT_W:0] d2;

   always_comb begin
      d2           = {d, 1'b0};
      out_of_range = ({1'b0, d} >= RAD);
      t            = '0;
      if (out_of_range) begin
         t = '0;
      end else if (!dbl) begin
         t = d;
      end else if (d2 >= RAD) begin
         // 2d < 2*RADIX, so one fold (subtract RADIX, add the carry digit 1) suffices.
         t = DIGIT_W'(d2 - RAD + (DIGIT_W+1)'(1));
      end else begin
         t = DIGIT_W'(d2);
      end
   end

endmodule

// File: rtl/luhn_mod_n.sv
// rtl/luhn_mod_n.sv - streaming Luhn mod-N verify / check-digit generate engine
//
// Ports:
//   clock, rst_n                 clock (rising edge), async active-low reset
//   size, size_mode, size_valid  message length and mode (0 verify, 1 generate)
//   size_ready                   block can take a new size
//   data, data_valid, data_ready digit stream, leftmost digit first
//   check, check_digit,          registered result: pass flag, computed check
//   check_err, check_valid,      digit, out-of-range flag, result handshake
//   check_ready

module luhn_mod_n
   import luhn_pkg::*;
#(
   parameter int DIGIT_W = 4,
   parameter int RADIX   = 16,
   parameter int SIZE_W  = 8
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic [SIZE_W-1:0]  size,
   input  logic               size_mode,
   input  logic               size_valid,
   output logic               size_ready,
   input  logic [DIGIT_W-1:0] data,
   input  logic               data_valid,
   output logic               data_ready,
   output logic               check,
   output logic [DIGIT_W-1:0] check_digit,
   output logic               check_err,
   output logic               check_valid,
   input  logic               check_ready
);

   localparam logic [DIGIT_W:0] RAD = (DIGIT_W+1)'(RADIX);

   luhn_state_t        state;
   luhn_state_t        state_nxt;
   logic               mode;
   logic [SIZE_W-1:0]  rem;
   logic [DIGIT_W:0]   acc;
   logic               err;

   logic               size_xfer;
   logic               data_xfer;
   logic               result_xfer;
   logic               dbl;
   logic [DIGIT_W-1:0] term;
   logic               term_oor;
   logic [DIGIT_W:0]   acc_sum;
   logic [DIGIT_W:0]   acc_nxt;

   assign size_xfer   = size_valid && size_ready;
   assign data_xfer   = data_valid && data_ready;
   assign result_xfer = check_valid && check_ready;

   // rem counts down to 1 on the rightmost digit; its parity against the mode
   // selects the doubled positions for both verify and generate.
   assign dbl = (rem[0] == mode);

   luhn_mod_n_term #(
      .DIGIT_W (DIGIT_W),
      .RADIX   (RADIX)
   ) u_term (
      .d            (data),
      .dbl          (dbl),
      .t            (term),
      .out_of_range (term_oor)
   );

   // acc and term are both < RADIX, so a single conditional subtract keeps acc reduced.
   always_comb begin
      acc_sum = acc + {1'b0, term};
      acc_nxt = (acc_sum >= RAD) ? (acc_sum - RAD) : acc_sum;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (size_xfer) state_nxt = (size == '0) ? CALC : LOAD;
         LOAD: if (data_xfer && (rem == SIZE_W'(1))) state_nxt = CALC;
         CALC: state_nxt = DONE;
         DONE: if (result_xfer) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         mode        <= MODE_VERIFY;
         rem         <= '0;
         acc         <= '0;
         err         <= 1'b0;
         size_ready  <= 1'b0;
         data_ready  <= 1'b0;
         check_valid <= 1'b0;
         check       <= 1'b0;
         check_digit <= '0;
         check_err   <= 1'b0;
      end else begin
         // size_ready and check_valid trail the state by one edge, so a new
         // size is never taken on the edge that consumes the previous result.
         size_ready  <= (state == IDLE) && (state_nxt == IDLE);
         check_valid <= (state == DONE) && (state_nxt == DONE);
         // data_ready follows the next state so it drops with the last digit.
         data_ready  <= (state_nxt == LOAD);

         if (size_xfer) begin
            mode <= size_mode;
            rem  <= size;
            acc  <= '0;
            err  <= 1'b0;
         end

         if (data_xfer) begin
            acc <= acc_nxt;
            rem <= rem - SIZE_W'(1);
            if (term_oor) err <= 1'b1;
         end

         if (state == CALC) begin
            check_err <= err;
            if (err) begin
               check       <= 1'b0;
               check_digit <= '0;
            end else begin
               check       <= (mode == MODE_GEN) ? 1'b1 : (acc == '0);
               check_digit <= (acc == '0) ? '0 : DIGIT_W'(RAD - acc);
            end
         end
      end
   end

endmodule

// File: tb/tb_luhn_mod_n.sv
// tb/tb_luhn_mod_n.sv - scoreboard bench: instance 0 RADIX=16, instance 1 RADIX=10

module tb_luhn_mod_n;

   typedef struct packed {
      logic       c;
      logic [3:0] d;
      logic       e;
   } res_t;

   localparam int BUDGET = 300;

   logic       clock = 1'b0;
   logic       rst_n;
   logic [7:0] size        [2];
   logic       size_mode   [2];
   logic       size_valid  [2];
   logic       size_ready  [2];
   logic [3:0] data        [2];
   logic       data_valid  [2];
   logic       data_ready  [2];
   logic       check       [2];
   logic [3:0] check_digit [2];
   logic       check_err   [2];
   logic       check_valid [2];
   logic       check_ready [2];

   int         n_checks = 0;
   int         n_pass   = 0;
   res_t       exp_q0[$];
   res_t       exp_q1[$];
   logic [3:0] msg [0:15];
   res_t       prev_r    [2];
   logic       prev_hold [2];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      luhn_mod_n #(
         .DIGIT_W (4),
         .RADIX   ((g == 0) ? 16 : 10),
         .SIZE_W  (8)
      ) dut (
         .clock       (clock),
         .rst_n       (rst_n),
         .size        (size[g]),
         .size_mode   (size_mode[g]),
         .size_valid  (size_valid[g]),
         .size_ready  (size_ready[g]),
         .data        (data[g]),
         .data_valid  (data_valid[g]),
         .data_ready  (data_ready[g]),
         .check       (check[g]),
         .check_digit (check_digit[g]),
         .check_err   (check_err[g]),
         .check_valid (check_valid[g]),
         .check_ready (check_ready[g])
      );
   end

   function automatic void chk(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endfunction

   function automatic void expect_res(int u, logic c, logic [3:0] d, logic e);
      res_t r;
      r = {c, d, e};
      if (u == 0) exp_q0.push_back(r);
      else exp_q1.push_back(r);
   endfunction

   function automatic void set_msg(logic [63:0] v, int n);
      for (int i = 0; i < n; i++) msg[i] = v[4*(n-1-i) +: 4];
   endfunction

   function automatic logic rdy(int u, int ch);
      case (ch)
         0:       return size_ready[u];
         1:       return data_ready[u];
         default: return check_valid[u] && check_ready[u];
      endcase
   endfunction

   // Returns #1 after the edge that performs the transfer.
   task automatic wait_xfer(int u, int ch, string name);
      logic ok;
      int   n;
      n = 0;
      do begin
         @(negedge clock);
         ok = rdy(u, ch);
         @(posedge clock);
         n++;
      end while (!ok && n < BUDGET);
      if (!ok) chk($sformatf("%s_timeout", name), 0, 1);
      #1;
   endtask

   task automatic send_size(int u, int n, logic m);
      size[u]       = 8'(n);
      size_mode[u]  = m;
      size_valid[u] = 1'b1;
      wait_xfer(u, 0, "size");
      size_valid[u] = 1'b0;
   endtask

   task automatic send_digits(int u, int n, int gap);
      for (int i = 0; i < n; i++) begin
         if (gap > 0) begin
            data_valid[u] = 1'b0;
            repeat ($urandom_range(1, gap)) @(posedge clock);
            #1;
         end
         data[u]       = msg[i];
         data_valid[u] = 1'b1;
         wait_xfer(u, 1, "data");
      end
      data_valid[u] = 1'b0;
   endtask

   task automatic take_result(int u, int delay);
      repeat (delay) @(posedge clock);
      #1;
      check_ready[u] = 1'b1;
      wait_xfer(u, 2, "result");
      check_ready[u] = 1'b0;
   endtask

   task automatic chk_zero(int u, string tag);
      chk({tag, "_size_ready"},  size_ready[u],  0);
      chk({tag, "_data_ready"},  data_ready[u],  0);
      chk({tag, "_check_valid"}, check_valid[u], 0);
      chk({tag, "_check"},       check[u],       0);
      chk({tag, "_check_digit"}, check_digit[u], 0);
      chk({tag, "_check_err"},   check_err[u],   0);
   endtask

   // Monitor: pops the scoreboard on each result transfer and checks that a
   // stalled result does not change.
   always @(negedge clock) begin : monitor
      res_t e;
      for (int u = 0; u < 2; u++) begin
         if (rst_n && check_valid[u]) begin
            if (prev_hold[u]) begin
               chk($sformatf("u%0d_hold_check", u), check[u], prev_r[u].c);
               chk($sformatf("u%0d_hold_digit", u), check_digit[u], prev_r[u].d);
            end
            if (check_ready[u]) begin
               if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
                  chk($sformatf("u%0d_unexpected_result", u), 1, 0);
               end else begin
                  if (u == 0) e = exp_q0.pop_front();
                  else e = exp_q1.pop_front();
                  chk($sformatf("u%0d_check", u), check[u], e.c);
                  chk($sformatf("u%0d_check_digit", u), check_digit[u], e.d);
                  chk($sformatf("u%0d_check_err", u), check_err[u], e.e);
               end
            end
         end
         prev_hold[u] <= rst_n && check_valid[u] && !check_ready[u];
         prev_r[u]    <= {check[u], check_digit[u], check_err[u]};
      end
   end

   initial begin
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         size[u] = '0; size_mode[u] = 1'b0; size_valid[u] = 1'b0;
         data[u] = '0; data_valid[u] = 1'b0; check_ready[u] = 1'b0;
         prev_hold[u] = 1'b0; prev_r[u] = '0;
      end
      #2;
      chk_zero(0, "rst_u0");
      chk_zero(1, "rst_u1");
      @(posedge clock);
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      chk("rel_size_ready_pre", size_ready[0], 0);
      @(posedge clock);
      #1;
      chk("rel_size_ready", size_ready[0], 1);

      // Verify A3DC1597 (valid), result two edges after the last digit
      set_msg(64'hA3DC1597, 8);
      expect_res(0, 1'b1, 4'h0, 1'b0);
      send_size(0, 8, 1'b0);
      send_digits(0, 8, 0);
      chk("t1_data_ready_drop", data_ready[0], 0);
      chk("t1_lat_e0", check_valid[0], 0);
      @(posedge clock); #1;
      chk("t1_lat_e1", check_valid[0], 0);
      @(posedge clock); #1;
      chk("t1_lat_e2", check_valid[0], 1);
      take_result(0, 0);

      // Generate on A3DC159 -> 7; verify 694321AB fails with remainder 5
      set_msg(64'hA3DC159, 7);
      expect_res(0, 1'b1, 4'h7, 1'b0);
      send_size(0, 7, 1'b1);
      send_digits(0, 7, 0);
      take_result(0, 0);
      set_msg(64'h694321AB, 8);
      expect_res(0, 1'b0, 4'hB, 1'b0);
      send_size(0, 8, 1'b0);
      send_digits(0, 8, 0);
      take_result(0, 0);

      // Gapped digits and a stalled result
      set_msg(64'hDEADBEEFCC9C, 12);
      expect_res(0, 1'b1, 4'h0, 1'b0);
      send_size(0, 12, 1'b0);
      send_digits(0, 12, 8);
      take_result(0, 5);

      // RADIX=10 instance
      set_msg(64'h79927398713, 11);
      expect_res(1, 1'b1, 4'h0, 1'b0);
      send_size(1, 11, 1'b0);
      send_digits(1, 11, 0);
      take_result(1, 0);
      set_msg(64'h7992739871, 10);
      expect_res(1, 1'b1, 4'h3, 1'b0);
      send_size(1, 10, 1'b1);
      send_digits(1, 10, 0);
      take_result(1, 0);
      set_msg(64'h7992A398713, 11);
      expect_res(1, 1'b0, 4'h0, 1'b1);
      send_size(1, 11, 1'b0);
      send_digits(1, 11, 0);
      chk("t4_err_all_consumed", data_ready[1], 0);
      take_result(1, 2);

      // size=0 back-to-back with size_valid and check_ready held high
      expect_res(0, 1'b1, 4'h0, 1'b0);
      expect_res(0, 1'b1, 4'h0, 1'b0);
      size[0] = 8'd0; size_mode[0] = 1'b0;
      size_valid[0] = 1'b1; check_ready[0] = 1'b1;
      wait_xfer(0, 0, "t5_size");
      chk("t5_no_data_ready_s0", data_ready[0], 0);
      chk("t5_lat_s0", check_valid[0], 0);
      @(posedge clock); #1;
      chk("t5_no_data_ready_s1", data_ready[0], 0);
      chk("t5_lat_s1", check_valid[0], 0);
      @(posedge clock); #1;
      chk("t5_lat_s2", check_valid[0], 1);
      @(posedge clock); #1;
      chk("t5_taken_valid_low", check_valid[0], 0);
      chk("t5_size_ready_h0", size_ready[0], 0);
      @(posedge clock); #1;
      chk("t5_size_ready_h1", size_ready[0], 1);
      wait_xfer(0, 2, "t5_result2");
      size_valid[0] = 1'b0;
      check_ready[0] = 1'b0;

      // Reset after 3 of 8 digits, then a full message
      set_msg(64'hA3DC1597, 8);
      send_size(0, 8, 1'b0);
      send_digits(0, 3, 0);
      chk("t6_data_ready_pre", data_ready[0], 1);
      rst_n = 1'b0;
      #1;
      chk_zero(0, "t6_rst");
      repeat (2) @(posedge clock);
      #1;
      rst_n = 1'b1;
      @(posedge clock); #1;
      chk("t6_size_ready", size_ready[0], 1);
      expect_res(0, 1'b1, 4'h0, 1'b0);
      send_size(0, 8, 1'b0);
      send_digits(0, 8, 0);
      take_result(0, 0);

      repeat (3) @(posedge clock);
      chk("q0_drained", exp_q0.size(), 0);
      chk("q1_drained", exp_q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
